// File: rtl/sensor_bridge_pkg.sv
// sensor_bridge_pkg: register map offsets, STATUS layout and timestamp type for mmio_sensor_bridge
package sensor_bridge_pkg;
    localparam int OFF_STATUS  = 0;
    localparam int OFF_COUNTER = 1;
    localparam int OFF_OUTPUT  = 2;
    localparam int OFF_CTRL    = 3;
    localparam int OFF_LAST_TS = 4;
    localparam int CH_BASE     = 5;
    localparam int CH_STRIDE   = 2;
    localparam int OVF_SHIFT   = 16;
    localparam int TS_W        = 32;
    typedef logic [TS_W-1:0] ts_t;
    function automatic int data_off(input int ch);
        return CH_BASE + CH_STRIDE * ch;
    endfunction
    function automatic int cnt_off(input int ch);
        return CH_BASE + CH_STRIDE * ch + 1;
    endfunction
endpackage

// File: rtl/sensor_fifo.sv
// sensor_fifo: circular capture FIFO with wrap-around pointers; flush empties it and cancels a concurrent push
module sensor_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & ~reset & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    // storage written only on accepted pushes
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers and occupancy; a pop frees the slot a same-edge push into a full FIFO needs
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mmio_sensor_bridge.sv
// mmio_sensor_bridge: MMIO window of per-channel capture FIFOs, COUNTER/OUTPUT/CTRL registers in front of dmem.
// Define SENSOR_TIMESTAMP_EN to tag each captured sample with COUNTER and expose the popped tag via LAST_TS.
module mmio_sensor_bridge
    import sensor_bridge_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int MMIO_BASE  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_data,
    input  logic                     cpu_wren,
    input  logic                     cpu_ren,
    output logic [DATA_W-1:0]        cpu_q,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     mem_wren,
    input  logic [DATA_W-1:0]        mem_q,
    input  logic [NUM_CH*DATA_W-1:0] sensor_in,
    input  logic [NUM_CH-1:0]        sensor_save,
    output logic [DATA_W-1:0]        sensor_output,
    output logic                     load_pulse
);
    localparam int WIN = CH_BASE + CH_STRIDE * NUM_CH;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
`ifdef SENSOR_TIMESTAMP_EN
    typedef struct packed { ts_t ts; logic [DATA_W-1:0] data; } entry_t;
`else
    typedef struct packed { logic [DATA_W-1:0] data; } entry_t;
`endif
    logic in_window, wr;
    logic [ADDR_W-1:0] off;
    logic [DATA_W-1:0] reg_rdata, output_reg;
    logic [31:0] status;
    ts_t counter;
`ifdef SENSOR_TIMESTAMP_EN
    ts_t last_ts;
`endif
    logic [NUM_CH-1:0] ctrl, save_q, ovf, push, pop, flush, fifo_full, fifo_empty;
    entry_t fifo_dout [NUM_CH];
    logic [CW-1:0] fifo_count [NUM_CH];
    assign in_window     = (cpu_addr >= ADDR_W'(MMIO_BASE)) && (cpu_addr < ADDR_W'(MMIO_BASE + WIN));
    assign off           = cpu_addr - ADDR_W'(MMIO_BASE);
    assign wr            = in_window & cpu_wren;
    assign mem_addr      = cpu_addr;
    assign mem_data      = cpu_data;
    assign mem_wren      = cpu_wren & ~in_window;
    assign cpu_q         = in_window ? reg_rdata : mem_q;
    assign sensor_output = output_reg;
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            entry_t din;
            assign push[i]  = sensor_save[i] & ~save_q[i] & ctrl[i];
            assign pop[i]   = in_window & cpu_ren & ~cpu_wren & (off == ADDR_W'(data_off(i)));
            assign flush[i] = wr & (off == ADDR_W'(cnt_off(i)));
`ifdef SENSOR_TIMESTAMP_EN
            assign din = {counter, sensor_in[i*DATA_W +: DATA_W]};
`else
            assign din = sensor_in[i*DATA_W +: DATA_W];
`endif
            sensor_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clock(clock),
                .reset(reset),
                .push(push[i]),
                .pop(pop[i]),
                .flush(flush[i]),
                .din(din),
                .dout(fifo_dout[i]),
                .count(fifo_count[i]),
                .full(fifo_full[i]),
                .empty(fifo_empty[i])
            );
        end
    endgenerate
    // STATUS: non-empty flags in the low half, overflow stickies in the high half
    always_comb begin
        status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            status[c]             = ~fifo_empty[c];
            status[OVF_SHIFT + c] = ovf[c];
        end
    end
    // register read mux; unmapped and write-only-absent fields read as zero
    always_comb begin
        reg_rdata = '0;
        if (off == ADDR_W'(OFF_STATUS)) reg_rdata = DATA_W'(status);
        if (off == ADDR_W'(OFF_COUNTER)) reg_rdata = DATA_W'(counter);
        if (off == ADDR_W'(OFF_OUTPUT)) reg_rdata = output_reg;
        if (off == ADDR_W'(OFF_CTRL)) reg_rdata = DATA_W'(ctrl);
`ifdef SENSOR_TIMESTAMP_EN
        if (off == ADDR_W'(OFF_LAST_TS)) reg_rdata = DATA_W'(last_ts);
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (off == ADDR_W'(data_off(c))) reg_rdata = fifo_dout[c].data;
            if (off == ADDR_W'(cnt_off(c))) reg_rdata = DATA_W'(fifo_count[c]);
        end
    end
    // free-running timestamp counter, reloadable by the CPU
    always_ff @(posedge clock) begin
        if (reset) counter <= '0;
        else counter <= (wr && off == ADDR_W'(OFF_COUNTER)) ? TS_W'(cpu_data) : counter + TS_W'(1);
    end
    // OUTPUT/CTRL registers, output strobe and save edge-detect history
    always_ff @(posedge clock) begin
        if (reset) begin
            output_reg <= '0;
            ctrl       <= '1;
            load_pulse <= 1'b0;
            save_q     <= '0;
        end else begin
            save_q     <= sensor_save;
            load_pulse <= wr && off == ADDR_W'(OFF_OUTPUT);
            if (wr && off == ADDR_W'(OFF_OUTPUT)) output_reg <= cpu_data;
            if (wr && off == ADDR_W'(OFF_CTRL)) ctrl <= cpu_data[NUM_CH-1:0];
        end
    end
    // overflow stickies: set on a dropped sample, cleared by a flush
    always_ff @(posedge clock) begin
        if (reset) ovf <= '0;
        else for (int c = 0; c < NUM_CH; c++) begin
            if (flush[c]) ovf[c] <= 1'b0;
            else if (push[c] && fifo_full[c] && !pop[c]) ovf[c] <= 1'b1;
        end
    end
`ifdef SENSOR_TIMESTAMP_EN
    // LAST_TS captures the timestamp of whichever entry is popped
    always_ff @(posedge clock) begin
        if (reset) last_ts <= '0;
        else for (int c = 0; c < NUM_CH; c++) begin
            if (pop[c] && !fifo_empty[c]) last_ts <= fifo_dout[c].ts;
        end
    end
`endif
endmodule

// File: tb/tb_mmio_sensor_bridge.sv
// tb_mmio_sensor_bridge: scoreboard bench for mmio_sensor_bridge against a queue-based register model
module tb_mmio_sensor_bridge;
    localparam int NUM_CH = 4, DATA_W = 32, ADDR_W = 12, DEPTH = 8, BASE = 1, WIN = 5 + 2 * NUM_CH;
    logic clock = 1'b0, reset = 1'b1;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_data = '0, mem_q = '0;
    logic cpu_wren = 1'b0, cpu_ren = 1'b0;
    logic [NUM_CH*DATA_W-1:0] sensor_in = '0;
    logic [NUM_CH-1:0] sensor_save = '0;
    logic [DATA_W-1:0] cpu_q, mem_data, sensor_output;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_wren, load_pulse;
    always #5 clock = ~clock;
    mmio_sensor_bridge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
        .cpu_ren(cpu_ren), .cpu_q(cpu_q), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .sensor_in(sensor_in), .sensor_save(sensor_save), .sensor_output(sensor_output),
        .load_pulse(load_pulse)
    );
    int total = 0, bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_data [NUM_CH][$];
    logic [31:0] m_ts [NUM_CH][$];
    logic [NUM_CH-1:0] m_ovf = '0, m_ctrl = '1, m_saveq = '0;
    logic [31:0] m_cnt = 0, m_out = 0, m_lts = 0;
    logic m_lp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic bit in_win(input logic [ADDR_W-1:0] a);
        return int'(a) >= BASE && int'(a) < BASE + WIN;
    endfunction

    function automatic logic [ADDR_W-1:0] d_addr(input int c);
        return ADDR_W'(BASE + 5 + 2 * c);
    endfunction

    function automatic logic [ADDR_W-1:0] n_addr(input int c);
        return ADDR_W'(BASE + 6 + 2 * c);
    endfunction

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        int o, c;
        logic [31:0] r;
        if (!in_win(a)) return mem_q;
        o = int'(a) - BASE;
        r = 0;
        if (o == 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r[k] = m_data[k].size() > 0;
                r[16 + k] = m_ovf[k];
            end
            return r;
        end
        if (o == 1) return m_cnt;
        if (o == 2) return m_out;
        if (o == 3) return 32'(m_ctrl);
`ifdef SENSOR_TIMESTAMP_EN
        if (o == 4) return m_lts;
`else
        if (o == 4) return 0;
`endif
        c = (o - 5) / 2;
        if ((o - 5) % 2 == 0) return m_data[c].size() > 0 ? m_data[c][0] : 0;
        return 32'(m_data[c].size());
    endfunction

    task automatic model_edge();
        int o;
        bit w;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_data[c].delete();
                m_ts[c].delete();
            end
            m_ovf = '0; m_ctrl = '1; m_saveq = '0; m_cnt = 0; m_out = 0; m_lts = 0; m_lp = 0;
            return;
        end
        o = in_win(cpu_addr) ? int'(cpu_addr) - BASE : -1;
        w = cpu_wren && o >= 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w && o == 6 + 2 * c) begin
                m_data[c].delete();
                m_ts[c].delete();
                m_ovf[c] = 0;
            end else begin
                if (cpu_ren && !cpu_wren && o == 5 + 2 * c && m_data[c].size() > 0) begin
                    void'(m_data[c].pop_front());
                    m_lts = m_ts[c].pop_front();
                end
                if (sensor_save[c] && !m_saveq[c] && m_ctrl[c]) begin
                    if (m_data[c].size() < DEPTH) begin
                        m_data[c].push_back(sensor_in[c*DATA_W +: DATA_W]);
                        m_ts[c].push_back(m_cnt);
                    end else m_ovf[c] = 1;
                end
            end
        end
        m_saveq = sensor_save;
        m_lp = w && o == 2;
        if (m_lp) m_out = cpu_data;
        if (w && o == 3) m_ctrl = cpu_data[NUM_CH-1:0];
        m_cnt = (w && o == 1) ? cpu_data : m_cnt + 1;
    endtask

    task automatic tick();
        if (cpu_ren && !reset) exp_q.push_back(model_read(cpu_addr));
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        cpu_addr = a; cpu_wren = 0; cpu_ren = 1;
        tick();
        cpu_ren = 0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_data = d; cpu_wren = 1;
        tick();
        cpu_wren = 0;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m);
        sensor_save = m;
        tick();
        sensor_save = 0;
        tick();
    endtask

    // monitor: every presented read is popped from the scoreboard; pass-through and strobe outputs every cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (cpu_ren) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cpu_q: no expected entry, got %h", cpu_q);
                end else check("cpu_q", cpu_q, exp_q.pop_front());
            end
            check("mem_wren", 32'(mem_wren), 32'(cpu_wren && !in_win(cpu_addr)));
            check("mem_addr", 32'(mem_addr), 32'(cpu_addr));
            check("sensor_output", sensor_output, m_out);
            check("load_pulse", 32'(load_pulse), 32'(m_lp));
        end
    end

    initial begin
        int r;
        repeat (3) tick();
        reset = 0;
        for (int o = 0; o < 5; o++) rd(ADDR_W'(BASE + o));
        mem_q = 32'hDEADBEEF;
        rd(100);
        wr(100, 32'h55);
        sensor_in[32 +: 32] = 32'hA5;
        sensor_save = 4'b0010;
        repeat (3) tick();
        sensor_save = 0;
        tick();
        rd(n_addr(1)); rd(BASE); rd(d_addr(1)); rd(n_addr(1));
        for (int k = 1; k <= 9; k++) begin
            sensor_in[0 +: 32] = k;
            pulse(4'b0001);
        end
        rd(n_addr(0)); rd(BASE);
        repeat (8) rd(d_addr(0));
        wr(n_addr(0), 0);
        rd(BASE);
        wr(BASE + 3, 0);
        pulse(4'hF);
        rd(BASE);
        wr(BASE + 2, 32'h1234);
        tick(); tick();
        rd(BASE + 2);
        wr(BASE + 2, 32'h1234);
        wr(BASE + 3, 32'hF);
        for (int k = 0; k < 8; k++) begin
            sensor_in[64 +: 32] = 100 + k;
            pulse(4'b0100);
        end
        sensor_in[64 +: 32] = 999;
        sensor_save = 4'b0100;
        rd(d_addr(2));
        sensor_save = 0;
        tick();
        rd(n_addr(2)); rd(BASE);
        sensor_save = 4'b0100;
        wr(n_addr(2), 0);
        sensor_save = 0;
        rd(n_addr(2)); rd(BASE);
        wr(BASE + 1, 1000);
        repeat (3) tick();
        sensor_in[96 +: 32] = 77;
        pulse(4'b1000);
        tick();
        rd(d_addr(3)); rd(BASE + 4);
        wr(BASE + 1, 32'hFFFFFFFF);
        rd(BASE + 1); rd(BASE + 1);
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 199);
            reset = (r == 0);
            cpu_addr = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(0, 4095)) : ADDR_W'($urandom_range(0, WIN + 1));
            cpu_wren = $urandom_range(0, 9) < 2;
            cpu_ren = $urandom_range(0, 9) < 6;
            cpu_data = (cpu_addr == BASE + 3 && $urandom_range(0, 1) == 1) ? 32'hF : $urandom;
            mem_q = $urandom;
            sensor_in = {$urandom, $urandom, $urandom, $urandom};
            sensor_save = NUM_CH'($urandom);
            tick();
        end
        reset = 0; cpu_wren = 0; cpu_ren = 0; sensor_save = 0;
        for (int c = 0; c < NUM_CH; c++) rd(n_addr(c));
        rd(BASE);
        repeat (2) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
